inst_issue_queue: RTL and testbench
===================================

INST_ISSUE_QUEUE -- requirements
Module: inst_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, power-of-two FIFO depth (2..16).
REQ-002 Parameter HAZARD_STALL, default 1, 1 enables RAW interlock, 0 issues with no interlock.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream instruction valid.
REQ-006 in_inst  input  8  instruction, fields {op[7:6], rs1[5:4], rs2[3:2], rd[1:0]}; op 00=NOP, 01=ADD, 10=SUB, 11=AND.
REQ-007 in_ready  output  1  queue accepts in_inst this cycle.
REQ-008 hold  input  1  downstream stall request; forces a bubble.
REQ-009 flush  input  1  discard all queued instructions.
REQ-010 issue_inst  output  8  registered instruction driven to the pipeline inst port; 8'h00 = bubble.
REQ-011 issue_valid  output  1  registered; 1 when issue_inst came from the FIFO.
REQ-012 fifo_count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 issued_cnt  output  16  instructions popped since reset, saturating.
REQ-014 bubble_cnt  output  16  stall bubbles since reset, saturating.

Function
REQ-015 in_ready SHALL equal (fifo_count < DEPTH) && !flush, combinational from registered state only.
REQ-016 Push SHALL occur when in_valid && in_ready; no bypass: a pushed entry is issuable no earlier than the next cycle.
REQ-017 Full: in_ready=0 even if a pop occurs the same cycle; push with pop on a non-full, non-empty FIFO SHALL leave fifo_count unchanged.
REQ-018 Write pointer and read pointer SHALL wrap modulo DEPTH; no entry is lost or duplicated across wrap.
REQ-019 Write-enabled op: op != 00; writes rd.
REQ-020 In-flight tracker: two entries T1 (issued last cycle), T2 (issued two cycles ago), each {wen, rd}; every cycle T2<=T1, T1<={wen,rd} of the instruction loaded into issue_inst (wen=0 for bubbles).
REQ-021 hazard = HAZARD_STALL && head op != 00 && (Tk.wen && Tk.rd matches head rs1 or rs2, for k=1 or 2).
REQ-022 Pop SHALL occur when fifo_count>0 && !hold && !flush && !hazard; issue_inst<=head, issue_valid<=1.
REQ-023 Otherwise issue_inst<=8'h00, issue_valid<=0.
REQ-024 NOP entries in the FIFO SHALL be issued as-is (issue_valid=1), never hazard-checked.
REQ-025 Issue latency: entry at FIFO head with no block appears on issue_inst one cycle later; minimum push-to-issue latency 2 cycles.
REQ-026 issued_cnt SHALL increment on every pop; bubble_cnt SHALL increment on every cycle fifo_count>0 and no pop occurs; both saturate at 16'hFFFF.
REQ-027 flush SHALL zero both pointers and fifo_count next cycle, load issue_inst<=8'h00, issue_valid<=0; tracker T1/T2 SHALL still shift (in-flight writes remain); flush cycle increments neither counter.
REQ-028 flush has priority over hold, hazard and push; simultaneous in_valid is dropped (in_ready=0).
REQ-029 hold and hazard together SHALL count one bubble.

Reset
REQ-030 On rst: pointers=0, fifo_count=0, issue_inst=8'h00, issue_valid=0, T1=T2={0,00}, issued_cnt=0, bubble_cnt=0; in_ready=1 the cycle after rst deasserts.
REQ-031 rst mid-operation SHALL discard all queued entries and in-flight tracking; rst has priority over flush, push and pop.
REQ-032 FIFO storage contents need no reset.

Verification
REQ-033 Push 8'h41 (ADD r0,r0->r1) then idle, HAZARD_STALL=1 -> issue_inst=8'h41 two cycles after push, issue_valid=1, issued_cnt=1, bubble_cnt=0.
REQ-034 Push 8'h41 then 8'h51 (ADD r1,r0->r1) back-to-back -> 8'h41, then two bubbles, then 8'h51; bubble_cnt=2; with HAZARD_STALL=0 -> back-to-back issue, bubble_cnt=0.
REQ-035 Push DEPTH+1 instructions with hold=1 -> in_ready=0 after 4th push, fifo_count=4, issue_inst=8'h00, bubble_cnt increments each held cycle; release hold -> 4 issued in order, pointers wrap, then fifo_count=0.
REQ-036 Fill 3 entries, assert flush with in_valid=1 -> next cycle fifo_count=0, issue_inst=8'h00, pushed entry dropped; an entry pushed after flush issues normally while T1/T2 hazards from pre-flush issues still hold.
REQ-037 Assert rst while 2 entries queued and one issuing -> next cycle all outputs at reset values; no queued instruction ever appears on issue_inst.
REQ-038 Force bubble_cnt to 16'hFFFE via long hold -> two more stall cycles leave it at 16'hFFFF.

Source files
------------

// File: rtl/inst_issue_queue.sv
// Instruction issue queue: a small FIFO that feeds the pipeline one
// instruction per cycle, inserting bubbles on downstream hold or on a
// read-after-write hazard against the two most recently issued instructions.
//
// Handshake: upstream push happens on a cycle where in_valid && in_ready.
// in_ready is combinational from registered occupancy and the flush input
// only, so it never depends on in_valid. There is no pop-side handshake:
// issue_inst/issue_valid are registered and the pipeline consumes every cycle.
module inst_issue_queue #(
    parameter int DEPTH        = 4,
    parameter bit HAZARD_STALL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_inst,
    output logic                     in_ready,
    input  logic                     hold,
    input  logic                     flush,
    output logic [7:0]               issue_inst,
    output logic                     issue_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              issued_cnt,
    output logic [15:0]              bubble_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_issue_inst;
    logic          r_issue_valid;
    logic          r_t1_wen;
    logic [1:0]    r_t1_rd;
    logic          r_t2_wen;
    logic [1:0]    r_t2_rd;
    logic [15:0]   r_issued_cnt;
    logic [15:0]   r_bubble_cnt;

    logic [7:0]    w_head;
    logic          w_not_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_hazard;
    logic          w_t1_hit;
    logic          w_t2_hit;

    // Head decode, RAW hazard check and push/pop decisions.
    always_comb begin
        w_head      = r_mem[r_rptr];
        w_not_empty = (r_count != '0);
        in_ready    = (r_count < DEPTH_C) && !flush;
        w_push      = in_valid && in_ready;
        w_t1_hit    = r_t1_wen && ((r_t1_rd == w_head[5:4]) || (r_t1_rd == w_head[3:2]));
        w_t2_hit    = r_t2_wen && ((r_t2_rd == w_head[5:4]) || (r_t2_rd == w_head[3:2]));
        // NOP at the head never reads a register, so it is never held back.
        w_hazard    = HAZARD_STALL && (w_head[7:6] != 2'b00) && (w_t1_hit || w_t2_hit);
        w_pop       = w_not_empty && !hold && !flush && !w_hazard;
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_inst;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue register: head on a pop, otherwise a bubble (8'h00).
    always_ff @(posedge clk) begin
        if (rst || flush || !w_pop) begin
            r_issue_inst  <= 8'h00;
            r_issue_valid <= 1'b0;
        end else begin
            r_issue_inst  <= w_head;
            r_issue_valid <= 1'b1;
        end
    end

    // In-flight write tracker; keeps shifting through a flush because
    // already-issued writes are still travelling down the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_t1_wen <= 1'b0;
            r_t1_rd  <= 2'b00;
            r_t2_wen <= 1'b0;
            r_t2_rd  <= 2'b00;
        end else begin
            r_t2_wen <= r_t1_wen;
            r_t2_rd  <= r_t1_rd;
            if (w_pop) begin
                r_t1_wen <= (w_head[7:6] != 2'b00);
                r_t1_rd  <= w_head[1:0];
            end else begin
                r_t1_wen <= 1'b0;
                r_t1_rd  <= 2'b00;
            end
        end
    end

    // Saturating statistics; a flush cycle counts as neither issue nor bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issued_cnt <= 16'h0000;
            r_bubble_cnt <= 16'h0000;
        end else if (!flush) begin
            if (w_pop) begin
                if (r_issued_cnt != 16'hFFFF) r_issued_cnt <= r_issued_cnt + 16'h0001;
            end else if (w_not_empty) begin
                if (r_bubble_cnt != 16'hFFFF) r_bubble_cnt <= r_bubble_cnt + 16'h0001;
            end
        end
    end

    assign issue_inst  = r_issue_inst;
    assign issue_valid = r_issue_valid;
    assign fifo_count  = r_count;
    assign issued_cnt  = r_issued_cnt;
    assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_inst_issue_queue.sv
// Bench for inst_issue_queue: two instances (interlock on / off) share the
// same stimulus and are compared every cycle against a queue-based model.
module tb_inst_issue_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid;
    logic [7:0]    in_inst;
    logic          hold;
    logic          flush;

    logic          hs_in_ready, nh_in_ready;
    logic [7:0]    hs_issue_inst, nh_issue_inst;
    logic          hs_issue_valid, nh_issue_valid;
    logic [CW-1:0] hs_fifo_count, nh_fifo_count;
    logic [15:0]   hs_issued_cnt, nh_issued_cnt;
    logic [15:0]   hs_bubble_cnt, nh_bubble_cnt;

    inst_issue_queue #(.DEPTH(DEPTH), .HAZARD_STALL(1'b1)) dut_hs (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(hs_in_ready), .hold(hold), .flush(flush),
        .issue_inst(hs_issue_inst), .issue_valid(hs_issue_valid),
        .fifo_count(hs_fifo_count), .issued_cnt(hs_issued_cnt),
        .bubble_cnt(hs_bubble_cnt)
    );

    inst_issue_queue #(.DEPTH(DEPTH), .HAZARD_STALL(1'b0)) dut_nh (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(nh_in_ready), .hold(hold), .flush(flush),
        .issue_inst(nh_issue_inst), .issue_valid(nh_issue_valid),
        .fifo_count(nh_fifo_count), .issued_cnt(nh_issued_cnt),
        .bubble_cnt(nh_bubble_cnt)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // Index 0 = interlock off, 1 = interlock on.  The queue holds pending
    // instructions; hist1/hist2 are the words issued one and two cycles ago.
    logic [7:0]  mq0[$];
    logic [7:0]  mq1[$];
    logic [7:0]  m_iss   [2];
    logic        m_val   [2];
    logic [7:0]  m_hist1 [2];
    logic [7:0]  m_hist2 [2];
    int unsigned m_issued[2];
    int unsigned m_bub   [2];

    function automatic int qsize(input int m);
        return (m != 0) ? mq1.size() : mq0.size();
    endfunction

    function automatic logic [7:0] qfront(input int m);
        return (m != 0) ? mq1[0] : mq0[0];
    endfunction

    task automatic qpop(input int m);
        if (m != 0) void'(mq1.pop_front()); else void'(mq0.pop_front());
    endtask

    task automatic qpush(input int m, input logic [7:0] x);
        if (m != 0) mq1.push_back(x); else mq0.push_back(x);
    endtask

    task automatic qclear(input int m);
        if (m != 0) mq1.delete(); else mq0.delete();
    endtask

    // True when an already-issued word writes a register the head reads.
    function automatic bit writes_read_reg(input logic [7:0] past, input logic [7:0] head);
        return (past[7:6] != 2'b00) &&
               ((past[1:0] == head[5:4]) || (past[1:0] == head[3:2]));
    endfunction

    task automatic model_step(input int m, input logic v, input logic [7:0] inst,
                              input logic h, input logic f, input logic r);
        int   n;
        bit   rdy;
        bit   pop;
        bit   hz;
        logic [7:0] hd;
        n   = qsize(m);
        rdy = (n < DEPTH) && !f;
        if (r) begin
            qclear(m);
            m_iss[m] = 8'h00; m_val[m] = 1'b0;
            m_hist1[m] = 8'h00; m_hist2[m] = 8'h00;
            m_issued[m] = 0; m_bub[m] = 0;
        end else if (f) begin
            qclear(m);
            m_iss[m] = 8'h00; m_val[m] = 1'b0;
            m_hist2[m] = m_hist1[m]; m_hist1[m] = 8'h00;
        end else begin
            pop = 1'b0;
            hd  = 8'h00;
            if (n > 0) begin
                hd  = qfront(m);
                hz  = (m != 0) && (hd[7:6] != 2'b00) &&
                      (writes_read_reg(m_hist1[m], hd) || writes_read_reg(m_hist2[m], hd));
                pop = !h && !hz;
            end
            m_hist2[m] = m_hist1[m];
            if (pop) begin
                qpop(m);
                m_iss[m] = hd; m_val[m] = 1'b1; m_hist1[m] = hd;
                if (m_issued[m] < 32'hFFFF) m_issued[m]++;
            end else begin
                m_iss[m] = 8'h00; m_val[m] = 1'b0; m_hist1[m] = 8'h00;
                if (n > 0 && m_bub[m] < 32'hFFFF) m_bub[m]++;
            end
            if (v && rdy) qpush(m, inst);
        end
    endtask

    // ---------------- scoreboard / checks ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("hs_issue_inst",  16'(hs_issue_inst),  16'(m_iss[1]));
        chk("hs_issue_valid", 16'(hs_issue_valid), 16'(m_val[1]));
        chk("hs_fifo_count",  16'(hs_fifo_count),  16'(qsize(1)));
        chk("hs_issued_cnt",  hs_issued_cnt,       16'(m_issued[1]));
        chk("hs_bubble_cnt",  hs_bubble_cnt,       16'(m_bub[1]));
        chk("nh_issue_inst",  16'(nh_issue_inst),  16'(m_iss[0]));
        chk("nh_issue_valid", 16'(nh_issue_valid), 16'(m_val[0]));
        chk("nh_fifo_count",  16'(nh_fifo_count),  16'(qsize(0)));
        chk("nh_issued_cnt",  nh_issued_cnt,       16'(m_issued[0]));
        chk("nh_bubble_cnt",  nh_bubble_cnt,       16'(m_bub[0]));
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after a rising edge; in_ready is checked
    // before the next edge, registered outputs 1 unit after it.
    task automatic step(input logic v, input logic [7:0] inst, input logic h,
                        input logic f, input logic r);
        in_valid = v; in_inst = inst; hold = h; flush = f; rst = r;
        #1;
        chk("hs_in_ready", 16'(hs_in_ready), 16'((qsize(1) < DEPTH) && !f));
        chk("nh_in_ready", 16'(nh_in_ready), 16'((qsize(0) < DEPTH) && !f));
        @(posedge clk);
        model_step(0, v, inst, h, f, r);
        model_step(1, v, inst, h, f, r);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst = 8'h00; hold = 1'b0; flush = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_iss[m] = 8'h00; m_val[m] = 1'b0; m_hist1[m] = 8'h00; m_hist2[m] = 8'h00;
            m_issued[m] = 0; m_bub[m] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_outputs();

        // Single ADD: visible two cycles after push, no bubbles.
        do_reset();
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("single_issue_inst", 16'(hs_issue_inst), 16'h0041);
        chk("single_issued",     hs_issued_cnt,      16'h0001);
        chk("single_bubbles",    hs_bubble_cnt,      16'h0000);
        idle(2);

        // Dependent pair: two interlock bubbles, none without interlock.
        do_reset();
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h51, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("raw_nh_back_to_back", 16'(nh_issue_inst), 16'h0051);
        chk("raw_hs_bubble",       16'(hs_issue_inst), 16'h0000);
        idle(2);
        chk("raw_hs_issue",        16'(hs_issue_inst), 16'h0051);
        chk("raw_hs_bubble_cnt",   hs_bubble_cnt,      16'h0002);
        chk("raw_nh_bubble_cnt",   nh_bubble_cnt,      16'h0000);
        idle(2);

        // Fill under hold past DEPTH, then drain with wrap.
        do_reset();
        step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h46, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h8B, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hC0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        chk("full_count",    16'(hs_fifo_count), 16'(DEPTH));
        chk("full_in_ready", 16'(hs_in_ready),   16'h0000);
        chk("full_bubble",   16'(hs_issue_inst), 16'h0000);
        idle(12);
        chk("drain_issued",  hs_issued_cnt,      16'h0004);
        chk("drain_count",   16'(hs_fifo_count), 16'h0000);
        step(1'b1, 8'h2D, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Flush with a simultaneous push, tracker keeps shifting.
        do_reset();
        step(1'b1, 8'h43, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        chk("flush_count", 16'(hs_fifo_count), 16'h0000);
        chk("flush_inst",  16'(hs_issue_inst), 16'h0000);
        step(1'b1, 8'h7C, 1'b0, 1'b0, 1'b0);
        idle(5);

        // Reset while entries are queued and one is issuing.
        step(1'b1, 8'h1E, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h6B, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_count", 16'(hs_fifo_count), 16'h0000);
        chk("rst_mid_valid", 16'(hs_issue_valid), 16'h0000);
        idle(5);

        // Randomized mix.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 59) == 0);
        end

        // Bubble counter saturation via a long hold.
        do_reset();
        step(1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
        while (m_bub[1] < 32'hFFFE) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("sat_fffe", hs_bubble_cnt, 16'hFFFE);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("sat_ffff_hs", hs_bubble_cnt, 16'hFFFF);
        chk("sat_ffff_nh", nh_bubble_cnt, 16'hFFFF);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
